// File: rtl/dn_route_loader.sv
// dn_route_loader: loads route bits for a distribution network from a beat
// stream, pulses set_en once the configuration is complete, then streams data
// vectors into the network with a one-cycle registered latency.
module dn_route_loader #(
  parameter  int unsigned N         = 64,
  parameter  int unsigned DW_DATA   = 8,
  parameter  int unsigned CFG_W     = 32,
  localparam int unsigned N_LEVELS  = 2 * $clog2(N) - 1,
  localparam int unsigned RT_BITS   = (N_LEVELS - 1) * N,
  localparam int unsigned NUM_BEATS = (RT_BITS + CFG_W - 1) / CFG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic                   cfg_last,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [N*DW_DATA-1:0]   din,
  input  logic                   din_last,
  output logic [RT_BITS-1:0]     route_signals,
  output logic                   set_en,
  output logic                   route_en,
  output logic [N*DW_DATA-1:0]   dn_in,
  output logic                   busy,
  output logic                   cfg_err
);

  localparam int unsigned K_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SET   = 2'd2;
  localparam logic [1:0] ROUTE = 2'd3;

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [K_W-1:0] k;
  logic [K_W-1:0] k_nxt;
  logic           err_nxt;
  logic           cfg_acc;
  logic           din_acc;
  logic [31:0]    beat_sel;

  assign cfg_acc  = cfg_valid && ((state == IDLE) || (state == LOAD));
  assign din_acc  = din_valid && (state == ROUTE);
  assign beat_sel = 32'(k);

  // Next-state, beat counter and framing-error decode
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    err_nxt   = cfg_err;
    case (state)
      IDLE, LOAD: begin
        if (cfg_acc) begin
          if (k == K_LAST) begin
            state_nxt = SET;
            k_nxt     = '0;
            if (!cfg_last) err_nxt = 1'b1;
          end else if (cfg_last) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = LOAD;
            k_nxt     = k + K_W'(1);
          end
        end
      end
      SET: state_nxt = ROUTE;
      ROUTE: begin
        if (din_acc && din_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, beat counter and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      k       <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      cfg_err <= err_nxt;
    end
  end

  // Handshake/status outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ready <= 1'b1;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      set_en    <= 1'b0;
    end else begin
      cfg_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
      din_ready <= (state_nxt == ROUTE);
      busy      <= (state_nxt != IDLE);
      set_en    <= (state_nxt == SET);
    end
  end

  // Route-bit store; bits of the last beat beyond RT_BITS are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_signals <= '0;
    end else if (cfg_acc) begin
      for (int unsigned i = 0; i < RT_BITS; i++) begin
        if (32'(i / CFG_W) == beat_sel) route_signals[i] <= cfg_data[i % CFG_W];
      end
    end
  end

  // Data path: register accepted vector and pulse route_en the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dn_in    <= '0;
      route_en <= 1'b0;
    end else begin
      route_en <= din_acc;
      if (din_acc) dn_in <= din;
    end
  end

endmodule

// File: tb/tb_dn_route_loader.sv
// Directed bench for dn_route_loader: default (N=64) instance plus an N=4 instance.
module tb_dn_route_loader;

  logic         clk;
  logic         reset;

  logic         cfg_valid, cfg_ready, cfg_last;
  logic [31:0]  cfg_data;
  logic         din_valid, din_ready, din_last;
  logic [511:0] din, dn_in;
  logic [639:0] route_signals;
  logic         set_en, route_en, busy, cfg_err;

  logic         s_cfg_valid, s_cfg_ready, s_cfg_last;
  logic [31:0]  s_cfg_data;
  logic         s_din_valid, s_din_ready, s_din_last;
  logic [31:0]  s_din, s_dn_in;
  logic [7:0]   s_route_signals;
  logic         s_set_en, s_route_en, s_busy, s_cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  dn_route_loader #(.N(64), .DW_DATA(8), .CFG_W(32)) u64 (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .din_valid(din_valid), .din_ready(din_ready), .din(din), .din_last(din_last),
    .route_signals(route_signals), .set_en(set_en), .route_en(route_en),
    .dn_in(dn_in), .busy(busy), .cfg_err(cfg_err)
  );

  dn_route_loader #(.N(4), .DW_DATA(8), .CFG_W(32)) u4 (
    .clk(clk), .reset(reset),
    .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .cfg_data(s_cfg_data), .cfg_last(s_cfg_last),
    .din_valid(s_din_valid), .din_ready(s_din_ready), .din(s_din), .din_last(s_din_last),
    .route_signals(s_route_signals), .set_en(s_set_en), .route_en(s_route_en),
    .dn_in(s_dn_in), .busy(s_busy), .cfg_err(s_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic valid;
    logic last;
    int   vid;
    logic exp_route_en;
    int   exp_vid;
    logic exp_busy;
    logic exp_din_ready;
  } vec_t;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mkvec(input int id);
    logic [511:0] v;
    v = '0;
    for (int e = 0; e < 64; e++) v[e*8 +: 8] = 8'((id * 64 + e) % 256);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [639:0] exp_rs;
  logic [511:0] exp_dn;
  vec_t         tbl[6];

  initial begin
    reset = 1'b0;
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    din_valid = 1'b0; din_last = 1'b0; din = '0;
    s_cfg_valid = 1'b0; s_cfg_last = 1'b0; s_cfg_data = '0;
    s_din_valid = 1'b0; s_din_last = 1'b0; s_din = '0;

    // stream table: idle cycle, 4 back-to-back vectors, then a hold cycle
    tbl[0] = '{1'b0, 1'b0, 0, 1'b0, -1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 0, 1'b1,  0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1, 1'b1,  1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 2, 1'b1,  2, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 3, 1'b1,  3, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 0, 1'b0,  3, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_din_ready", din_ready, 1'b0);
    chk("rst_set_en", set_en, 1'b0);
    chk("rst_route_en", route_en, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_route_signals", route_signals, '0);
    chk("rst_dn_in", dn_in, '0);
    chk("rst_s_cfg_ready", s_cfg_ready, 1'b1);
    @(negedge clk) reset = 1'b1;
    tick();

    // full 20-beat load
    exp_rs = '0;
    for (int b = 0; b < 20; b++) begin
      cfg_valid = 1'b1; cfg_data = 32'hA5A5A5A5; cfg_last = (b == 19);
      exp_rs[b*32 +: 32] = 32'hA5A5A5A5;
      tick();
      chk("load_set_en", set_en, (b == 19));
      if (b == 0) chk("load_busy", busy, 1'b1);
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("load_route_signals", route_signals, exp_rs);
    chk("load_cfg_err", cfg_err, 1'b0);
    chk("load_cfg_ready_set", cfg_ready, 1'b0);
    tick();
    chk("set_pulse_end", set_en, 1'b0);
    chk("route_din_ready", din_ready, 1'b1);

    // streaming
    for (int i = 0; i < 6; i++) begin
      din_valid = tbl[i].valid; din_last = tbl[i].last; din = mkvec(tbl[i].vid);
      tick();
      din_valid = 1'b0; din_last = 1'b0;
      exp_dn = (tbl[i].exp_vid < 0) ? '0 : mkvec(tbl[i].exp_vid);
      chk("stream_route_en", route_en, tbl[i].exp_route_en);
      chk("stream_dn_in", dn_in, exp_dn);
      chk("stream_busy", busy, tbl[i].exp_busy);
      chk("stream_din_ready", din_ready, tbl[i].exp_din_ready);
      chk("stream_no_set_en", set_en, 1'b0);
    end

    // early cfg_last on beat 5
    for (int b = 0; b < 6; b++) begin
      cfg_valid = 1'b1; cfg_data = 32'h00001000 + 32'(b); cfg_last = (b == 5);
      tick();
      if (b == 4) chk("early_busy_mid", busy, 1'b1);
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("early_cfg_err", cfg_err, 1'b1);
    chk("early_idle", busy, 1'b0);
    chk("early_no_set_en", set_en, 1'b0);
    chk("early_cfg_ready", cfg_ready, 1'b1);
    tick();
    chk("early_no_set_en2", set_en, 1'b0);

    // reload with din_valid held throughout LOAD/SET
    din_valid = 1'b1; din_last = 1'b1; din = mkvec(5);
    for (int b = 0; b < 20; b++) begin
      cfg_valid = 1'b1; cfg_data = (32'(b) * 32'h01010101) ^ 32'h5A000000; cfg_last = (b == 19);
      exp_rs[b*32 +: 32] = (32'(b) * 32'h01010101) ^ 32'h5A000000;
      tick();
      chk("bp_route_en_load", route_en, 1'b0);
      chk("bp_set_en", set_en, (b == 19));
    end
    chk("bp_cfg_err_sticky", cfg_err, 1'b1);
    chk("bp_route_signals", route_signals, exp_rs);
    cfg_valid = 1'b1; cfg_data = 32'hDEADBEEF; cfg_last = 1'b0;
    tick();
    chk("bp_route_din_ready", din_ready, 1'b1);
    chk("bp_route_en_set", route_en, 1'b0);
    chk("bp_cfg_ready_route", cfg_ready, 1'b0);
    tick();
    chk("bp_route_en_accept", route_en, 1'b1);
    chk("bp_dn_in", dn_in, mkvec(5));
    chk("bp_idle", busy, 1'b0);
    chk("bp_rs_held", route_signals, exp_rs);
    tick();
    din_valid = 1'b0; din_last = 1'b0;
    chk("bp_cfg_accept_busy", busy, 1'b1);
    chk("bp_no_route_en_idle", route_en, 1'b0);
    chk("bp_beat0", route_signals[31:0], 32'hDEADBEEF);

    // reset in the middle of a load
    for (int b = 1; b <= 10; b++) begin
      cfg_valid = 1'b1; cfg_data = 32'(b); cfg_last = 1'b0;
      tick();
    end
    cfg_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_route_signals", route_signals, '0);
    chk("mid_rst_dn_in", dn_in, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cfg_ready", cfg_ready, 1'b1);
    chk("mid_rst_din_ready", din_ready, 1'b0);
    chk("mid_rst_cfg_err", cfg_err, 1'b0);
    chk("mid_rst_set_en", set_en, 1'b0);
    chk("mid_rst_route_en", route_en, 1'b0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_set_en", set_en, 1'b0);
    exp_rs = '0;
    for (int b = 0; b < 20; b++) begin
      cfg_valid = 1'b1; cfg_data = 32'hC0DE0000 + 32'(b); cfg_last = (b == 19);
      exp_rs[b*32 +: 32] = 32'hC0DE0000 + 32'(b);
      tick();
      chk("post_rst_set_en_load", set_en, (b == 19));
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("post_rst_route_signals", route_signals, exp_rs);
    chk("post_rst_cfg_err", cfg_err, 1'b0);

    // N=4: single beat per configuration
    s_cfg_valid = 1'b1; s_cfg_data = 32'h12345A3C; s_cfg_last = 1'b1;
    tick();
    s_cfg_valid = 1'b0; s_cfg_last = 1'b0;
    chk("n4_set_en", s_set_en, 1'b1);
    chk("n4_route_signals", s_route_signals, 8'h3C);
    chk("n4_cfg_err", s_cfg_err, 1'b0);
    chk("n4_busy", s_busy, 1'b1);
    tick();
    chk("n4_set_en_end", s_set_en, 1'b0);
    chk("n4_din_ready", s_din_ready, 1'b1);
    s_din_valid = 1'b1; s_din_last = 1'b1; s_din = 32'hA1B2C3D4;
    tick();
    s_din_valid = 1'b0; s_din_last = 1'b0;
    chk("n4_route_en", s_route_en, 1'b1);
    chk("n4_dn_in", s_dn_in, 32'hA1B2C3D4);
    chk("n4_idle", s_busy, 1'b0);
    s_cfg_valid = 1'b1; s_cfg_data = 32'hFFFFFF77; s_cfg_last = 1'b0;
    tick();
    s_cfg_valid = 1'b0;
    chk("n4_nolast_set_en", s_set_en, 1'b1);
    chk("n4_nolast_cfg_err", s_cfg_err, 1'b1);
    chk("n4_nolast_route_signals", s_route_signals, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dn_route_loader.md
DN_ROUTE_LOADER -- requirements
Module: dn_route_loader

Interface
REQ-001 SHALL have parameter N, default 64, the distribution network port count (power of two, >=4).
REQ-002 SHALL have parameter DW_DATA, default 8, the element width.
REQ-003 SHALL have parameter CFG_W, default 32, the configuration beat width.
REQ-004 SHALL derive N_LEVELS = 2*clog2(N)-1, RT_BITS = (N_LEVELS-1)*N and NUM_BEATS = ceil(RT_BITS/CFG_W), which is 20 at the defaults.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_valid, input, 1 bit: a configuration beat is offered.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the loader accepts a configuration beat.
REQ-009 SHALL have port cfg_data, input, CFG_W bits: the route-bit beat.
REQ-010 SHALL have port cfg_last, input, 1 bit: the beat is the final beat of a configuration.
REQ-011 SHALL have port din_valid, input, 1 bit: a data vector is offered.
REQ-012 SHALL have port din_ready, output, 1 bit: the loader accepts a data vector.
REQ-013 SHALL have port din, input, N*DW_DATA bits: the vector; element k is at din[k*DW_DATA +: DW_DATA].
REQ-014 SHALL have port din_last, input, 1 bit: the final vector of a batch.
REQ-015 SHALL have port route_signals, output, RT_BITS bits: router r is at bits [2r+1:2r], the network route-signal array flattened.
REQ-016 SHALL have ports set_en and route_en, outputs, 1 bit each: network control pulses.
REQ-017 SHALL have port dn_in, output, N*DW_DATA bits: the vector presented to the network.
REQ-018 SHALL have ports busy and cfg_err, outputs, 1 bit each: busy means the loader is not in IDLE; cfg_err is a sticky framing error.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, SET and ROUTE.
REQ-020 SHALL drive cfg_ready=1 only in IDLE and LOAD, and din_ready=1 only in ROUTE.
REQ-021 SHALL accept a beat when cfg_valid and cfg_ready are both high, write it to route_signals[k*CFG_W +: CFG_W] (k = beat count), discard bits at index >= RT_BITS, and increment k.
REQ-022 SHALL move IDLE->LOAD on the first accepted beat, or IDLE->SET directly when NUM_BEATS=1.
REQ-023 SHALL move LOAD->SET on acceptance of beat NUM_BEATS-1, and clear k to 0.
REQ-024 SHALL, in SET, assert set_en for exactly one cycle (the cycle after the final beat is accepted) and then move to ROUTE.
REQ-025 SHALL hold route_signals stable from the cycle set_en is asserted until the next IDLE->LOAD transition.
REQ-026 SHALL, for each accepted vector in ROUTE, register din into dn_in and assert route_en for one cycle on the following cycle; throughput is 1 vector per cycle and latency is 1 cycle.
REQ-027 SHALL hold dn_in at its last value and route_en low when no vector is accepted.
REQ-028 SHALL move ROUTE->IDLE on acceptance of a vector with din_last=1; route_en for that vector is still emitted in the first IDLE cycle.
REQ-029 SHALL, when cfg_last=1 arrives on beat k < NUM_BEATS-1: set cfg_err, clear k, return to IDLE and issue no set_en.
REQ-030 SHALL, when the final beat arrives with cfg_last=0: set cfg_err and still proceed to SET.
REQ-031 SHALL keep cfg_err set until reset.
REQ-032 SHALL ignore cfg_valid in SET and ROUTE, and ignore din_valid outside ROUTE, with no state change.
REQ-033 SHALL never assert set_en and route_en in the same cycle.

Reset
REQ-034 SHALL, on reset low, asynchronously force state=IDLE, k=0, route_signals=0, dn_in=0, set_en=0, route_en=0 and cfg_err=0; the outputs then read busy=0, cfg_ready=1, din_ready=0.
REQ-035 SHALL treat reset asserted mid-LOAD or mid-ROUTE as discarding all partial configuration and any in-flight vector, with no pulse emitted after reset.
REQ-036 SHALL resume operation on the first rising clk edge after reset deasserts.

Verification
REQ-037 SHALL be verified for a full load: at N=64, 20 beats of 0xA5A5A5A5 with cfg_last on beat 19 -> set_en a single pulse 1 cycle after beat 19, route_signals = repeated 0xA5A5A5A5 (640 bits), no cfg_err.
REQ-038 SHALL be verified for streaming: 4 back-to-back vectors (element k = vector_id*64+k mod 256), din_last on the 4th -> route_en high for 4 consecutive cycles, dn_in matching each vector 1 cycle late, then busy=0.
REQ-039 SHALL be verified for an early last: cfg_last on beat 5 -> cfg_err=1, state IDLE, no set_en; a subsequent valid 20-beat load -> set_en, with cfg_err remaining 1.
REQ-040 SHALL be verified for backpressure: din_valid held during LOAD/SET and cfg_valid held during ROUTE -> no acceptance and no route_en until ROUTE; cfg beats accepted only after returning to IDLE.
REQ-041 SHALL be verified for reset mid-operation: reset asserted after beat 10 -> all outputs zero immediately; after release, a fresh 20-beat load completes normally.
REQ-042 SHALL be verified for the small configuration: N=4 (RT_BITS=8, NUM_BEATS=1) -> a single beat gives set_en on the next cycle, and cfg_data[31:8] is ignored.
